uart_boot_ctrl: RTL and testbench

Sequencer between the UART byte interface and the pipelined CPU. Decodes an ASCII command stream and assembles 8 hex digits into each 32-bit instruction word. Writes the words to instruction memory through a single write port, then starts the CPU and stops it on command or when the CPU halts. It owns the `start` level that the CPU core samples, and it echoes every consumed byte back through the UART transmitter.

---
 rtl/uart_boot_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_ctrl.sv
// rtl/uart_boot_ctrl.sv - UART command sequencer that loads instruction memory and starts/stops the CPU
module uart_boot_ctrl #(
    parameter int ADDR_W = 4,
    parameter int WORDS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_clr,
    input  logic              tx_busy,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              cpu_halt,
    output logic              cpu_run,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   word_cnt,
    output logic              load_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   WORDS_C   = (ADDR_W + 1)'(WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_G = 8'h47;
    localparam logic [7:0] CH_Q = 8'h51;
    localparam logic [7:0] CH_S = 8'h53;

    state_t            st;
    logic [31:0]       sr;
    logic [2:0]        nib_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              consume;
    logic              is_hex;
    logic [3:0]        nib;

    // rx_clr gating stops a second consume while the UART is still dropping rdy
    assign consume = rx_rdy & ~tx_busy & ~rx_clr;
    assign state   = st;
    assign cpu_run = (st == S_RUN);

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            is_hex = 1'b1;
            nib    = rx_data[3:0] + 4'd9;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= S_IDLE;
            sr         <= 32'd0;
            nib_cnt    <= 3'd0;
            wr_ptr     <= '0;
            rx_clr     <= 1'b0;
            tx_wr      <= 1'b0;
            tx_data    <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            word_cnt   <= '0;
            load_err   <= 1'b0;
        end else begin
            rx_clr  <= consume;
            tx_wr   <= consume;
            imem_we <= 1'b0;
            if (consume) begin
                tx_data <= rx_data;
            end

            case (st)
                S_IDLE, S_HALT: begin
                    if (consume && rx_data == CH_L) begin
                        st        <= S_LOAD;
                        sr        <= 32'd0;
                        nib_cnt   <= 3'd0;
                        wr_ptr    <= '0;
                        imem_addr <= '0;
                        word_cnt  <= '0;
                        load_err  <= 1'b0;
                    end else if (consume && rx_data == CH_G) begin
                        st <= S_RUN;
                    end
                end

                S_LOAD: begin
                    if (consume) begin
                        if (is_hex) begin
                            sr <= {sr[27:0], nib};
                            if (nib_cnt == 3'd7) begin
                                nib_cnt <= 3'd0;
                                if (word_cnt == WORDS_C) begin
                                    load_err <= 1'b1;
                                end else begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= wr_ptr;
                                    imem_wdata <= {sr[27:0], nib};
                                    word_cnt   <= word_cnt + 1'b1;
                                    if (wr_ptr != LAST_ADDR) begin
                                        wr_ptr <= wr_ptr + 1'b1;
                                    end
                                end
                            end else begin
                                nib_cnt <= nib_cnt + 3'd1;
                            end
                        end else if (rx_data == CH_G) begin
                            st      <= S_RUN;
                            sr      <= 32'd0;
                            nib_cnt <= 3'd0;
                        end else if (rx_data == CH_Q) begin
                            st      <= S_IDLE;
                            sr      <= 32'd0;
                            nib_cnt <= 3'd0;
                        end
                    end
                end

                S_RUN: begin
                    // A consumed S takes priority over a halt seen on the same edge
                    if (consume && rx_data == CH_S) begin
                        st <= S_IDLE;
                    end else if (cpu_halt) begin
                        st <= S_HALT;
                    end
                end

                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// tb/tb_uart_boot_ctrl.sv - directed self-checking bench for uart_boot_ctrl
module tb_uart_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_clr;
    logic        tx_busy = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_halt = 1'b0;
    logic        cpu_run;
    logic [1:0]  state;
    logic [4:0]  word_cnt;
    logic        load_err;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    int base;
    int clr_n;
    logic [7:0] echo_q[$];
    logic [7:0] sent_q[$];
    logic [3:0] we_addr_q[$];

    uart_boot_ctrl #(.ADDR_W(4), .WORDS(16)) dut (
        .clk(clk), .rst(rst),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr(rx_clr),
        .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_halt(cpu_halt), .cpu_run(cpu_run), .state(state),
        .word_cnt(word_cnt), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_wr) echo_q.push_back(tx_data);
        if (imem_we) begin
            we_cnt++;
            we_addr_q.push_back(imem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        sent_q.push_back(b);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rx_clr) seen = 1'b1;
        end
        rx_rdy = 1'b0;
        chk("consume_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_outs", {rx_clr, tx_wr, imem_we, cpu_run, load_err}, 32'd0);
        chk("rst_word_cnt", {27'd0, word_cnt}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single word load
        send_str("L12345678");
        chk("w1_we_cnt", we_cnt, 1);
        chk("w1_addr", {28'd0, imem_addr}, 32'd0);
        chk("w1_wdata", imem_wdata, 32'h12345678);
        chk("w1_word_cnt", {27'd0, word_cnt}, 32'd1);
        chk("w1_state", {30'd0, state}, 32'd1);
        chk("w1_echo_n", echo_q.size(), 9);

        send_byte("Q");
        chk("q_state", {30'd0, state}, 32'd0);

        // overflow: 17 words
        send_byte("L");
        base = we_cnt;
        for (int k = 0; k < 17; k++) begin
            send_str("00000013");
            if (k == 15) begin
                chk("ovf_16_err", {31'd0, load_err}, 32'd0);
                chk("ovf_16_cnt", {27'd0, word_cnt}, 32'd16);
            end
        end
        chk("ovf_we_cnt", we_cnt - base, 16);
        for (int k = 0; k < 16; k++) chk("ovf_addr", {28'd0, we_addr_q[base + k]}, k);
        chk("ovf_err", {31'd0, load_err}, 32'd1);
        chk("ovf_word_cnt", {27'd0, word_cnt}, 32'd16);
        chk("ovf_last_addr", {28'd0, imem_addr}, 32'd15);
        chk("ovf_wdata", imem_wdata, 32'h00000013);

        // partial word discarded by G, then halt
        send_byte("Q");
        base = we_cnt;
        send_str("L123G");
        chk("pg_we", we_cnt - base, 0);
        chk("pg_state", {30'd0, state}, 32'd2);
        chk("pg_run", {31'd0, cpu_run}, 32'd1);
        cpu_halt = 1'b1;
        @(negedge clk);
        chk("halt_state", {30'd0, state}, 32'd3);
        chk("halt_run", {31'd0, cpu_run}, 32'd0);
        cpu_halt = 1'b0;

        // restart, hex bytes in RUN, then S with simultaneous halt
        send_byte("G");
        chk("rerun_state", {30'd0, state}, 32'd2);
        base = we_cnt;
        send_str("DEADBEEF");
        chk("run_hex_we", we_cnt - base, 0);
        chk("run_hex_state", {30'd0, state}, 32'd2);
        sent_q.push_back("S");
        rx_data  = "S";
        rx_rdy   = 1'b1;
        cpu_halt = 1'b1;
        @(negedge clk);
        chk("s_halt_clr", {31'd0, rx_clr}, 32'd1);
        chk("s_halt_state", {30'd0, state}, 32'd0);
        rx_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_halt_state", {30'd0, state}, 32'd0);
        chk("idle_halt_run", {31'd0, cpu_run}, 32'd0);
        cpu_halt = 1'b0;

        // tx_busy holds off consumption
        clr_n = 0;
        tx_busy = 1'b1;
        rx_data = "x";
        rx_rdy  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_clr) clr_n++;
        end
        chk("busy_no_clr", clr_n, 0);
        base = echo_q.size();
        sent_q.push_back("x");
        tx_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_clr) begin
                clr_n++;
                rx_rdy = 1'b0;
            end
        end
        rx_rdy = 1'b0;
        chk("busy_one_clr", clr_n, 1);
        chk("busy_one_echo", echo_q.size() - base, 1);

        // reset mid-word
        send_str("L12345678");
        send_str("9ABCD");
        rst = 1'b1;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_word_cnt", {27'd0, word_cnt}, 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        chk("arst_txdata", {24'd0, tx_data}, 32'd0);
        chk("arst_outs", {rx_clr, tx_wr, imem_we, cpu_run, load_err, imem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = we_cnt;
        send_str("LABCDEF01");
        chk("post_rst_we", we_cnt - base, 1);
        chk("post_rst_addr", {28'd0, imem_addr}, 32'd0);
        chk("post_rst_wdata", imem_wdata, 32'hABCDEF01);
        chk("post_rst_cnt", {27'd0, word_cnt}, 32'd1);

        // every consumed byte echoed in order
        chk("echo_total", echo_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < echo_q.size(); i++)
            chk("echo_byte", {24'd0, echo_q[i]}, {24'd0, sent_q[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
